// File: rtl/adsr_envelope.sv
// ADSR envelope generator applied to a valid/ready sample stream.
// The envelope steps once per accepted sample; each output sample is the input scaled by the pre-step envelope.
module adsr_envelope #(
  parameter int unsigned width_p         = 12,
  parameter int unsigned env_width_p     = 12,
  parameter int unsigned attack_step_p   = 1024,
  parameter int unsigned decay_step_p    = 512,
  parameter int unsigned sustain_level_p = 2048,
  parameter int unsigned release_step_p  = 256
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   gate_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [width_p-1:0]     data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [width_p-1:0]     data_o,
  output logic [env_width_p-1:0] env_o,
  output logic                   active_o
);

  localparam int unsigned EW = env_width_p + 1;
  localparam int unsigned PW = width_p + env_width_p + 1;

  localparam logic [EW-1:0] ENV_MAX   = {1'b0, {env_width_p{1'b1}}};
  localparam logic [EW-1:0] ATK_STEP  = EW'(attack_step_p);
  localparam logic [EW-1:0] DEC_STEP  = EW'(decay_step_p);
  localparam logic [EW-1:0] SUS_LVL   = EW'(sustain_level_p);
  localparam logic [EW-1:0] REL_STEP  = EW'(release_step_p);
  localparam logic [EW-1:0] DEC_FLOOR = SUS_LVL + DEC_STEP;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } state_e;

  state_e                  state_q, state_d, eff_state;
  logic [env_width_p-1:0]  env_q, env_d;
  logic [width_p-1:0]      data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    active_q, active_d;
  logic                    accept;
  logic [EW-1:0]           env_x, env_sum, env_new;
  logic signed [PW-1:0]    prod;

  assign ready_o  = ~valid_q | ready_i;
  assign accept   = valid_i & ready_o;
  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign env_o    = env_q;
  assign active_o = active_q;

  // Gate edges are only observed on accepts: key-up releases, key-down (re)triggers.
  always_comb begin
    eff_state = state_q;
    if (gate_i) begin
      if (state_q == ST_IDLE || state_q == ST_RELEASE) eff_state = ST_ATTACK;
    end else begin
      if (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN)
        eff_state = ST_RELEASE;
    end
  end

  // Envelope step in one extra bit so saturation never sees a wrapped value.
  always_comb begin
    env_x   = {1'b0, env_q};
    env_sum = env_x + ATK_STEP;
    env_new = env_x;
    state_d = state_q;
    if (accept) begin
      state_d = eff_state;
      case (eff_state)
        ST_ATTACK: begin
          if (env_sum >= ENV_MAX) begin
            env_new = ENV_MAX;
            state_d = ST_DECAY;
          end else begin
            env_new = env_sum;
          end
        end
        ST_DECAY: begin
          if (env_x <= DEC_FLOOR) begin
            env_new = SUS_LVL;
            state_d = ST_SUSTAIN;
          end else begin
            env_new = env_x - DEC_STEP;
          end
        end
        ST_SUSTAIN: env_new = env_x;
        ST_RELEASE: begin
          if (env_x <= REL_STEP) begin
            env_new = '0;
            state_d = ST_IDLE;
          end else begin
            env_new = env_x - REL_STEP;
          end
        end
        ST_IDLE: env_new = '0;
        default: begin
          env_new = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
    env_d    = env_width_p'(env_new);
    active_d = (state_d != ST_IDLE);
  end

  // Scale by the envelope in force before this accept; |env| < 1.0 so the result cannot overflow.
  always_comb begin
    prod    = $signed(data_i) * $signed({1'b0, env_q});
    data_d  = data_q;
    valid_d = valid_q;
    if (accept) begin
      data_d  = width_p'(prod >>> env_width_p);
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      env_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end
  end

endmodule
